spm_bank_conflict_scheduler: RTL

//  Sequential successor to the scratchpad's combinational bank-conflict detector.
//  - Accepts one vector request: per-lane bank index, word address and lane mask.
//  - Issues it to the SPM banks over as many beats as needed; each beat is conflict-free.
//  - Tracks the pending lane mask internally.
//  - Optional read-broadcast merge: load lanes hitting the same bank and word share one beat.
//  - Saturating conflict-beat statistic counter.
//  - Sits between the SPM request stage and the bank array.

---
 rtl/spm_bank_conflict_scheduler.sv | 121 ++++++++++++
 1 files changed

// File: rtl/spm_bank_conflict_scheduler.sv
// rtl/spm_bank_conflict_scheduler.sv - serialises a vector SPM request into conflict-free bank beats
module spm_bank_conflict_scheduler #(
  parameter int LANES        = 16,
  parameter int BANKS        = 16,
  parameter int BANK_W       = $clog2(BANKS),
  parameter int WORD_W       = 10,
  parameter int BROADCAST_EN = 1,
  parameter int STAT_W       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [LANES-1:0]          req_mask,
  input  logic [LANES*BANK_W-1:0]   req_bank,
  input  logic [LANES*WORD_W-1:0]   req_word,
  input  logic                      req_is_store,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic [LANES-1:0]          issue_mask,
  output logic                      issue_last,
  output logic [LANES-1:0]          pending_mask,
  output logic                      busy,
  input  logic                      stat_clear,
  output logic [STAT_W-1:0]         conflict_beats
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0]                state;
  logic [LANES-1:0]          pending;
  logic [LANES*BANK_W-1:0]   bank_r;
  logic [LANES*WORD_W-1:0]   word_r;
  logic                      store_r;

  logic [IDX_W-1:0]          win_idx  [BANKS];
  logic [WORD_W-1:0]         win_word [BANKS];
  logic [LANES-1:0]          grant;
  logic                      beat_fire;

  // Per bank, find the lowest-index pending lane (scan high to low so the lowest wins)
  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      win_idx[b]  = '0;
      win_word[b] = '0;
    end
    for (int i = LANES - 1; i >= 0; i--) begin
      if (pending[i]) begin
        win_idx[bank_r[i*BANK_W +: BANK_W]]  = IDX_W'(i);
        win_word[bank_r[i*BANK_W +: BANK_W]] = word_r[i*WORD_W +: WORD_W];
      end
    end
  end

  // A lane is granted if it owns its bank this beat, or is a load reading the owner's word
  always_comb begin
    grant = '0;
    for (int i = 0; i < LANES; i++) begin
      grant[i] = pending[i] &&
                 ((win_idx[bank_r[i*BANK_W +: BANK_W]] == IDX_W'(i)) ||
                  ((BROADCAST_EN != 0) && !store_r &&
                   (word_r[i*WORD_W +: WORD_W] == win_word[bank_r[i*BANK_W +: BANK_W]])));
    end
  end

  // Outputs derive from registered state only
  always_comb begin
    req_ready    = (state == IDLE);
    issue_valid  = (state == ISSUE);
    busy         = (state == ISSUE);
    issue_mask   = issue_valid ? grant : '0;
    issue_last   = issue_valid && ((pending & ~grant) == '0);
    pending_mask = pending;
    beat_fire    = issue_valid && issue_ready;
  end

  // Request capture and beat-by-beat retirement of the pending lanes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pending <= '0;
      bank_r  <= '0;
      word_r  <= '0;
      store_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            pending <= req_mask;
            bank_r  <= req_bank;
            word_r  <= req_word;
            store_r <= req_is_store;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_ready) begin
            pending <= pending & ~grant;
            if (issue_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of beats beyond the first of each request; clear wins over increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_beats <= '0;
    end else if (stat_clear) begin
      conflict_beats <= '0;
    end else if (beat_fire && !issue_last && (conflict_beats != {STAT_W{1'b1}})) begin
      conflict_beats <= conflict_beats + 1'b1;
    end
  end

endmodule
